// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: input conditioning, 11-bit frame deframing and
// make/break/extended interpretation into a "last held key" view.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       keyPress,
    output logic       keyExtended,
    output logic [7:0] scanByte,
    output logic       scanValid,
    output logic       frameErr
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, RECV = 1'b1} state_t;

    // Odd parity over data plus parity bit, and the stop bit must be high.
    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return (^{data, par}) & stop;
    endfunction

    // Synchronizers idle high so reset does not fabricate an edge.
    logic           clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic           filt_clk_q, filt_clk_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           fall_s;
    state_t         state_q, state_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     data_q, data_d;
    logic           par_q, par_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic [7:0]     scan_byte_q, scan_byte_d;
    logic           scan_valid_q, scan_valid_d;
    logic           frame_err_q, frame_err_d;
    logic           brk_q, brk_d, ext_q, ext_d;
    logic [7:0]     keycode_q, keycode_d;
    logic           key_press_q, key_press_d;
    logic           key_ext_q, key_ext_d;

    // State register for synchronizers, filter, frame FSM and key state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            dat_meta_q   <= 1'b1;
            dat_sync_q   <= 1'b1;
            filt_clk_q   <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            data_q       <= 8'h00;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            scan_byte_q  <= 8'h00;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            keycode_q    <= 8'h00;
            key_press_q  <= 1'b0;
            key_ext_q    <= 1'b0;
        end else begin
            clk_meta_q   <= PS2_CLK;
            clk_sync_q   <= clk_meta_q;
            dat_meta_q   <= PS2_DAT;
            dat_sync_q   <= dat_meta_q;
            filt_clk_q   <= filt_clk_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            scan_byte_q  <= scan_byte_d;
            scan_valid_q <= scan_valid_d;
            frame_err_q  <= frame_err_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            keycode_q    <= keycode_d;
            key_press_q  <= key_press_d;
            key_ext_q    <= key_ext_d;
        end
    end

    // Glitch filter: accept a new clock level only after it persists; the
    // falling edge is flagged in the cycle the filtered level drops.
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        fall_s     = 1'b0;
        if (clk_sync_q != filt_clk_q) begin
            if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q;
                filt_cnt_d = '0;
                fall_s     = filt_clk_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FCW'(1);
            end
        end else begin
            filt_cnt_d = '0;
        end
    end

    // Frame FSM next state: start bit enters RECV; stop edge or timeout leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fall_s && !dat_sync_q) state_d = RECV;
                else                       state_d = IDLE;
            end
            RECV: begin
                if (fall_s && (bit_cnt_q == 4'd9))             state_d = IDLE;
                else if (!fall_s && (tmo_q == TCW'(TIMEOUT_CYCLES - 1))) state_d = IDLE;
                else                                           state_d = RECV;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath: bit capture, timeout counting, completion pulses.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        par_d        = par_q;
        tmo_d        = '0;
        scan_byte_d  = scan_byte_q;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall_s && !dat_sync_q) begin
                    bit_cnt_d = 4'd0;
                    data_d    = 8'h00;
                    par_d     = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            RECV: begin
                if (fall_s) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        data_d[bit_cnt_q[2:0]] = dat_sync_q;
                    end else if (bit_cnt_q == 4'd8) begin
                        par_d = dat_sync_q;
                    end else begin
                        bit_cnt_d = 4'd0;
                        if (frame_ok(data_q, par_q, dat_sync_q)) begin
                            scan_valid_d = 1'b1;
                            scan_byte_d  = data_q;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end else if (tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                    frame_err_d = 1'b1;
                    bit_cnt_d   = 4'd0;
                end else begin
                    tmo_d = tmo_q + TCW'(1);
                end
            end
            default: bit_cnt_d = 4'd0;
        endcase
    end

    // Protocol layer: prefix flags and the last-held-key view.
    always_comb begin
        brk_d       = brk_q;
        ext_d       = ext_q;
        keycode_d   = keycode_q;
        key_press_d = key_press_q;
        key_ext_d   = key_ext_q;
        if (scan_valid_q) begin
            case (scan_byte_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
                default: begin
                    if (brk_q) begin
                        // Only releasing the key currently shown clears keyPress.
                        if ((scan_byte_q == keycode_q) && (ext_q == key_ext_q)) key_press_d = 1'b0;
                        else                                                    key_press_d = key_press_q;
                    end else begin
                        keycode_d   = scan_byte_q;
                        key_ext_d   = ext_q;
                        key_press_d = 1'b1;
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
            endcase
        end else if (frame_err_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
        end else begin
            brk_d = brk_q;
        end
    end

    assign keycode     = keycode_q;
    assign keyPress    = key_press_q;
    assign keyExtended = key_ext_q;
    assign scanByte    = scan_byte_q;
    assign scanValid   = scan_valid_q;
    assign frameErr    = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: PS/2 frames driven bit by bit with
// ~20 Clk per half-period, FILTER_LEN = 4, TIMEOUT_CYCLES = 200.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] keycode;
    logic       key_press;
    logic       key_ext;
    logic [7:0] scan_byte;
    logic       scan_valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sv_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int sv_cyc = 0, fe_cyc = 0, kp_rise_cyc = 0;
    logic kp_prev = 1'b0;

    ps2_key_decoder #(.FILTER_LEN(4), .TIMEOUT_CYCLES(200)) dut (
        .Clk(clk), .Reset(reset), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .keycode(keycode), .keyPress(key_press), .keyExtended(key_ext),
        .scanByte(scan_byte), .scanValid(scan_valid), .frameErr(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling Clk edge.
    always @(negedge clk) begin
        if (scan_valid) begin sv_cnt++; sv_cyc = cyc; end
        if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
        if (scan_valid && frame_err) both_cnt++;
        if (key_press && !kp_prev) kp_rise_cyc = cyc;
        kp_prev = key_press;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set while clock high, then a low half-period.
    task automatic send_bit(input logic b);
        ps2_dat = b;
        wait_cyc(10);
        ps2_clk = 1'b0;
        wait_cyc(20);
        ps2_clk = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ par_flip);
        send_bit(stop);
        ps2_dat = 1'b1;
        wait_cyc(40);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    task automatic check_key(input string tag, input logic [7:0] kc, input logic kp, input logic ke);
        check_eq({tag, ".keycode"}, {24'd0, keycode}, {24'd0, kc});
        check_eq({tag, ".keyPress"}, {31'd0, key_press}, {31'd0, kp});
        check_eq({tag, ".keyExt"}, {31'd0, key_ext}, {31'd0, ke});
    endtask

    int sv0, fe0, t0, waited;

    initial begin
        wait_cyc(5);
        check_key("reset", 8'h00, 1'b0, 1'b0);
        check_eq("reset.scanByte", {24'd0, scan_byte}, 32'h00);
        check_eq("reset.scanValid", {31'd0, scan_valid}, 32'd0);
        check_eq("reset.frameErr", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        wait_cyc(20);

        // Basic make of 0x1C, with keyPress one cycle behind scanValid.
        sv0 = sv_cnt; fe0 = fe_cnt;
        send_good(8'h1C);
        check_eq("make1c.svcount", sv_cnt - sv0, 32'd1);
        check_eq("make1c.fecount", fe_cnt - fe0, 32'd0);
        check_eq("make1c.scanByte", {24'd0, scan_byte}, 32'h1C);
        check_eq("make1c.latency", kp_rise_cyc - sv_cyc, 32'd1);
        check_key("make1c", 8'h1C, 1'b1, 1'b0);

        send_good(8'hF0); send_good(8'h1C);
        check_key("brk1c", 8'h1C, 1'b0, 1'b0);
        send_good(8'hF0); send_good(8'h1C);
        check_key("brk1c_again", 8'h1C, 1'b0, 1'b0);

        // Last key wins; releasing the older key keeps keyPress.
        send_good(8'h1C);
        check_key("make1c_b", 8'h1C, 1'b1, 1'b0);
        send_good(8'h23);
        check_key("make23", 8'h23, 1'b1, 1'b0);
        send_good(8'hF0); send_good(8'h1C);
        check_key("brk_old1c", 8'h23, 1'b1, 1'b0);
        send_good(8'hF0); send_good(8'h23);
        check_key("brk23", 8'h23, 1'b0, 1'b0);

        // Extended key handling.
        send_good(8'hE0); send_good(8'h75);
        check_key("make_e075", 8'h75, 1'b1, 1'b1);
        send_good(8'hF0); send_good(8'h75);
        check_key("plain_brk75", 8'h75, 1'b1, 1'b1);
        send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
        check_key("ext_brk75", 8'h75, 1'b0, 1'b1);

        // Parity error.
        sv0 = sv_cnt; fe0 = fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        check_eq("parerr.svcount", sv_cnt - sv0, 32'd0);
        check_eq("parerr.fecount", fe_cnt - fe0, 32'd1);
        check_eq("parerr.scanByte", {24'd0, scan_byte}, 32'h75);
        check_key("parerr", 8'h75, 1'b0, 1'b1);

        // Stop bit error.
        sv0 = sv_cnt; fe0 = fe_cnt;
        send_frame(8'h23, 1'b0, 1'b0);
        check_eq("stoperr.svcount", sv_cnt - sv0, 32'd0);
        check_eq("stoperr.fecount", fe_cnt - fe0, 32'd1);
        check_eq("stoperr.scanByte", {24'd0, scan_byte}, 32'h75);

        // Timeout: start + 4 data bits, then silence.
        fe0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        ps2_dat = 1'b1;
        wait_cyc(10);
        t0 = cyc;
        ps2_clk = 1'b0;
        wait_cyc(20);
        ps2_clk = 1'b1;
        waited = 0;
        while (fe_cnt == fe0 && waited < 400) begin
            wait_cyc(1);
            waited++;
        end
        check_eq("timeout.fecount", fe_cnt - fe0, 32'd1);
        check_eq("timeout.window", ((fe_cyc - t0) >= 200 && (fe_cyc - t0) <= 212) ? 32'd1 : 32'd0, 32'd1);
        wait_cyc(20);
        sv0 = sv_cnt;
        send_good(8'h23);
        check_eq("after_tmo.svcount", sv_cnt - sv0, 32'd1);
        check_key("after_tmo", 8'h23, 1'b1, 1'b0);

        // One-cycle glitch low with data low must not start a frame.
        sv0 = sv_cnt; fe0 = fe_cnt;
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        wait_cyc(1);
        ps2_clk = 1'b1;
        wait_cyc(10);
        ps2_dat = 1'b1;
        wait_cyc(20);
        send_good(8'h1C);
        check_eq("glitch.svcount", sv_cnt - sv0, 32'd1);
        check_eq("glitch.fecount", fe_cnt - fe0, 32'd0);
        check_eq("glitch.scanByte", {24'd0, scan_byte}, 32'h1C);

        // Reset in the middle of a frame.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1;
        wait_cyc(3);
        check_key("midrst", 8'h00, 1'b0, 1'b0);
        check_eq("midrst.scanByte", {24'd0, scan_byte}, 32'h00);
        reset = 1'b0;
        wait_cyc(20);
        sv0 = sv_cnt; fe0 = fe_cnt;
        send_good(8'h1B);
        check_eq("post_rst.svcount", sv_cnt - sv0, 32'd1);
        check_eq("post_rst.fecount", fe_cnt - fe0, 32'd0);
        check_key("post_rst", 8'h1B, 1'b1, 1'b0);

        check_eq("never_both", both_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
